si5341_cfg_seq: RTL and testbench

Register-table sequencer that configures the Si5341A clock generator through the I2C byte engine (`i2c_ip`). On `start`, it walks an external ROM of command words and turns each word into byte writes. It tracks the Si5341A page register (0x01) and only rewrites it when the page changes. It executes delay entries, such as the 300 ms post-preamble wait, and reports done/error to the board bring-up logic.

---
 rtl/si5341_cfg_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_si5341_cfg_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si5341_cfg_seq.sv
// Si5341A register-table sequencer: walks a ROM of {op,page,addr,data} entries and drives the I2C byte engine.
// Latency: start -> busy next cycle, first byte request 4 cycles after start; 3 cycles of overhead per entry.
// Backpressure: one byte in flight; each request waits for its done (bounded by TIMEOUT_MS) before the next.
//
// Ports: clk/rst_n (async active-low); start/busy/done/err/err_code to bring-up logic;
//        rom_addr/rom_data table port (1-cycle ROM latency); i2c_* byte-engine handshake.
// Optional read-back verify of every register write is built when SI5341_VERIFY_EN is defined.
module si5341_cfg_seq #(
  parameter int SYS_CLK    = 50_000_000,
  parameter int ROM_AW     = 9,
  parameter int TIMEOUT_MS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [25:0]       rom_data,
  output logic              i2c_wr_req,
  output logic [7:0]        i2c_wr_data,
  output logic              i2c_last,
  input  logic              i2c_wr_done,
  output logic              i2c_rd_req,
  input  logic [7:0]        i2c_rd_data,
  input  logic              i2c_rd_done
);

  localparam int              PRE_N   = SYS_CLK / 1000;
  localparam int              PRE_W   = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_N - 1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_MS - 1);

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_DELAY   = 2'b01;
  localparam logic [1:0] EC_TIMEOUT = 2'b01;
  localparam logic [1:0] EC_OVERRUN = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, PG_REG, PG_VAL, RA, RD, DLY, VA, VR, DONE, ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [23:0]         ent_q, ent_d;      // {page, addr, data} of the current entry
  logic [7:0]          pg_q, pg_d;
  logic                pg_vld_q, pg_vld_d;
  logic                sent_q, sent_d;    // request of the current byte state already issued
  logic                wr_req_q, wr_req_d;
  logic                last_q, last_d;
  logic [7:0]          wr_dat_q, wr_dat_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [15:0]         ms_q, ms_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic                tick;
  logic                wr_ack;
  logic                timed_out;
  logic                adv;
  logic                to_err;
  logic [15:0]         dly_ms;

  assign tick      = (pre_q == PRE_MAX);
  // A done with no request issued in this state is a stray and is ignored.
  assign wr_ack    = sent_q & i2c_wr_done;
  assign timed_out = tick & (ms_q == TO_LAST);
  assign dly_ms    = ent_q[15:0];

`ifdef SI5341_VERIFY_EN
  logic rd_req_q, rd_req_d;
  logic rd_ack;
  assign rd_ack = sent_q & i2c_rd_done;
`else
  logic unused_rd;
  assign unused_rd = ^{i2c_rd_data, i2c_rd_done};
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ent_d    = ent_q;
    pg_d     = pg_q;
    pg_vld_d = pg_vld_q;
    sent_d   = sent_q;
    wr_req_d = 1'b0;
    last_d   = last_q;
    wr_dat_d = wr_dat_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    ms_d     = tick ? ms_q + 16'd1 : ms_q;
    err_d    = err_q;
    code_d   = code_q;
    adv      = 1'b0;
    to_err   = 1'b0;
`ifdef SI5341_VERIFY_EN
    rd_req_d = 1'b0;
`endif

    // First cycle of a byte state: launch its single request (registered, so it
    // appears on the port one cycle later and data/last are stable with it).
    if (!sent_q) begin
      case (state_q)
        PG_REG: begin wr_req_d = 1'b1; wr_dat_d = 8'h01;        last_d = 1'b0; sent_d = 1'b1; end
        PG_VAL: begin wr_req_d = 1'b1; wr_dat_d = ent_q[23:16]; last_d = 1'b1; sent_d = 1'b1; end
        RA:     begin wr_req_d = 1'b1; wr_dat_d = ent_q[15:8];  last_d = 1'b0; sent_d = 1'b1; end
        RD:     begin wr_req_d = 1'b1; wr_dat_d = ent_q[7:0];   last_d = 1'b1; sent_d = 1'b1; end
`ifdef SI5341_VERIFY_EN
        VA:     begin wr_req_d = 1'b1; wr_dat_d = ent_q[15:8];  last_d = 1'b1; sent_d = 1'b1; end
        VR:     begin rd_req_d = 1'b1; sent_d = 1'b1; end
`endif
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          addr_d   = '0;
          pg_vld_d = 1'b0;
          err_d    = 1'b0;
          code_d   = 2'b00;
        end
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        ent_d = rom_data[23:0];
        case (rom_data[25:24])
          OP_WRITE: state_d = (!pg_vld_q || (rom_data[23:16] != pg_q)) ? PG_REG : RA;
          OP_DELAY: state_d = DLY;
          default:  state_d = DONE;   // END and the reserved opcode
        endcase
      end
      PG_REG: begin
        if (wr_ack)         state_d = PG_VAL;
        else if (timed_out) to_err  = 1'b1;
      end
      PG_VAL: begin
        if (wr_ack) begin
          pg_d     = ent_q[23:16];
          pg_vld_d = 1'b1;
          state_d  = RA;
        end else if (timed_out) begin
          to_err = 1'b1;
        end
      end
      RA: begin
        if (wr_ack)         state_d = RD;
        else if (timed_out) to_err  = 1'b1;
      end
      RD: begin
`ifdef SI5341_VERIFY_EN
        if (wr_ack)         state_d = VA;
`else
        if (wr_ack)         adv     = 1'b1;
`endif
        else if (timed_out) to_err  = 1'b1;
      end
`ifdef SI5341_VERIFY_EN
      VA: begin
        if (wr_ack)         state_d = VR;
        else if (timed_out) to_err  = 1'b1;
      end
      VR: begin
        if (rd_ack) begin
          if (i2c_rd_data == ent_q[7:0]) begin
            adv = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b10;
          end
        end else if (timed_out) begin
          to_err = 1'b1;
        end
      end
`endif
      DLY: begin
        // Counters restart on entry, so N ms ends exactly N*PRE_N cycles in.
        if ((dly_ms == 16'd0) || (tick && ((ms_q + 16'd1) == dly_ms))) adv = 1'b1;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (to_err) begin
      state_d  = ERR;
      err_d    = 1'b1;
      code_d   = EC_TIMEOUT;
      pg_vld_d = 1'b0;
    end

    // Step to the next entry; the last ROM slot cannot be followed, so no wrap.
    if (adv) begin
      if (&addr_q) begin
        state_d = ERR;
        err_d   = 1'b1;
        code_d  = EC_OVERRUN;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
    end

    if (state_d != state_q) begin
      pre_d  = '0;
      ms_d   = '0;
      sent_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      ent_q    <= '0;
      pg_q     <= '0;
      pg_vld_q <= 1'b0;
      sent_q   <= 1'b0;
      wr_req_q <= 1'b0;
      last_q   <= 1'b0;
      wr_dat_q <= '0;
      pre_q    <= '0;
      ms_q     <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ent_q    <= ent_d;
      pg_q     <= pg_d;
      pg_vld_q <= pg_vld_d;
      sent_q   <= sent_d;
      wr_req_q <= wr_req_d;
      last_q   <= last_d;
      wr_dat_q <= wr_dat_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

`ifdef SI5341_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_req_q <= 1'b0;
    else        rd_req_q <= rd_req_d;
  end
  assign i2c_rd_req = rd_req_q;
`else
  assign i2c_rd_req = 1'b0;
`endif

  assign busy        = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign err_code    = code_q;
  assign rom_addr    = addr_q;
  assign i2c_wr_req  = wr_req_q;
  assign i2c_wr_data = wr_dat_q;
  assign i2c_last    = last_q;

endmodule

// File: tb/tb_si5341_cfg_seq.sv
`timescale 1ns/1ps
module tb_si5341_cfg_seq;
  localparam int SYS_CLK    = 10_000;   // 10 cycles per ms keeps delays short
  localparam int ROM_AW     = 4;
  localparam int TIMEOUT_MS = 10;
  localparam int DEPTH      = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [ROM_AW-1:0] rom_addr;
  logic [25:0] rom_data = '0;
  logic        i2c_wr_req, i2c_last, i2c_rd_req;
  logic [7:0]  i2c_wr_data;
  logic        i2c_wr_done = 1'b0;
  logic [7:0]  i2c_rd_data = '0;
  logic        i2c_rd_done = 1'b0;

  always #5 clk = ~clk;

  si5341_cfg_seq #(.SYS_CLK(SYS_CLK), .ROM_AW(ROM_AW), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_wr_req(i2c_wr_req), .i2c_wr_data(i2c_wr_data), .i2c_last(i2c_last),
    .i2c_wr_done(i2c_wr_done), .i2c_rd_req(i2c_rd_req), .i2c_rd_data(i2c_rd_data),
    .i2c_rd_done(i2c_rd_done)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [25:0] rom [DEPTH];
  logic [8:0]  exp_q [$];
  int  exp_code, exp_nbytes;
  int  done_cnt = 0, byte_cnt = 0;
  bit  eng_hang = 0, vr_corrupt = 0;
  int  lat_min = 1, lat_max = 4;
  int  spur_k = 0;
  int  first_req_k, done_k, end_k, bytes_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    chk_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic logic [25:0] e_wr(input logic [7:0] p, input logic [7:0] a, input logic [7:0] d);
    return {2'b00, p, a, d};
  endfunction
  function automatic logic [25:0] e_dly(input int ms);
    logic [15:0] m;
    m = ms[15:0];
    return {2'b01, 8'h00, m};
  endfunction
  function automatic logic [25:0] e_end(input logic [1:0] op);
    return {op, 24'h0};
  endfunction

  task automatic fill_end();
    for (int i = 0; i < DEPTH; i++) rom[i] = e_end(2'b10);
  endtask

  // Reference: walk the table as the datasheet procedure describes, emitting
  // {last,byte} for every I2C write and the final outcome (0 = done).
  task automatic model_push();
    logic [7:0] pg, p, a, d;
    logic [1:0] op;
    bit pv;
    pv = 0; pg = 0; exp_code = 0; exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      op = rom[i][25:24]; p = rom[i][23:16]; a = rom[i][15:8]; d = rom[i][7:0];
      if (op == 2'b00) begin
        if (!pv || p != pg) begin
          exp_q.push_back({1'b0, 8'h01});
          exp_q.push_back({1'b1, p});
          pg = p; pv = 1;
        end
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b1, d});
`ifdef SI5341_VERIFY_EN
        exp_q.push_back({1'b1, a});
        if (vr_corrupt) begin exp_code = 2; break; end
`endif
      end else if (op != 2'b01) begin
        break;
      end
      if (i == DEPTH - 1) exp_code = 3;
    end
    exp_nbytes = exp_q.size();
  endtask

  // ROM with one cycle of read latency
  initial begin
    logic [ROM_AW-1:0] a;
    forever begin
      @(negedge clk); a = rom_addr;
      @(posedge clk); #1 rom_data = rom[a];
    end
  end

  // I2C engine model; read returns the data byte written two bytes earlier
  initial begin
    int unsigned lat;
    logic [7:0] prev1, prev2;
    prev1 = 0; prev2 = 0;
    forever begin
      @(negedge clk);
      i2c_wr_done = 1'b0; i2c_rd_done = 1'b0;
      if (rst_n && i2c_wr_req && !eng_hang) begin
        prev2 = prev1; prev1 = i2c_wr_data;
        lat = $urandom_range(lat_min, lat_max);
        repeat (lat) @(negedge clk);
        i2c_wr_done = 1'b1;
      end else if (rst_n && i2c_rd_req) begin
        lat = $urandom_range(lat_min, lat_max);
        repeat (lat) @(negedge clk);
        i2c_rd_data = vr_corrupt ? (prev2 ^ 8'h01) : prev2;
        i2c_rd_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [8:0] e;
    logic [7:0] held;
    held = 0;
    forever begin
      @(negedge clk);
      if (i2c_wr_req) begin
        byte_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_byte: got %0b_%02h, expected no byte", i2c_last, i2c_wr_data);
        end else begin
          e = exp_q.pop_front();
          held = e[7:0];
          check("wr_byte", {23'd0, i2c_last, i2c_wr_data}, {23'd0, e});
        end
      end
      if (i2c_wr_done) check("wr_data_hold", {24'd0, i2c_wr_data}, {24'd0, held});
      if (done) done_cnt++;
    end
  end

  task automatic check_rst(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_wr_req"}, i2c_wr_req, 0);
    check({tag, "_rd_req"}, i2c_rd_req, 0);
    check({tag, "_last"}, i2c_last, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_wr_data"}, i2c_wr_data, 0);
  endtask

  task automatic run_table(input string tag, input int budget);
    int k, d0, b0;
    d0 = done_cnt; b0 = byte_cnt; first_req_k = -1; done_k = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (k < budget) begin
      @(negedge clk); k++;
      start = (k == spur_k);
      if (k == 1) begin
        check({tag, "_busy_c1"}, busy, 1);
        check({tag, "_addr_c1"}, rom_addr, 0);
        check({tag, "_err_clr"}, err, 0);
      end
      if (i2c_wr_req && first_req_k < 0) first_req_k = k;
      if (done) begin done_k = k; break; end
      if (err) break;
    end
    start = 1'b0;
    end_k = k;
    check({tag, "_finished"}, (done_k >= 0) || err, 1);
    repeat (4) @(negedge clk);
    bytes_run = byte_cnt - b0;
    check({tag, "_err"}, err, (exp_code != 0));
    check({tag, "_err_code"}, err_code, exp_code);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, (exp_code == 0));
    check({tag, "_nbytes"}, bytes_run, exp_nbytes);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_end();
    repeat (3) @(posedge clk);
    #1 check_rst("reset");
    rst_n = 1'b1;

    // Basic two writes on page 0, fixed 20-cycle engine latency
    rom[0] = e_wr(8'h00, 8'h0B, 8'h24); rom[1] = e_wr(8'h00, 8'h0C, 8'h01);
    lat_min = 20; lat_max = 20;
    model_push(); run_table("t1", 3000);
    check("t1_first_req_cycle", first_req_k, 4);

    // Page change between entries
    fill_end();
    rom[0] = e_wr(8'h02, 8'h35, 8'h10); rom[1] = e_wr(8'h03, 8'h35, 8'h11);
    lat_min = 1; lat_max = 6;
    model_push(); run_table("t2", 3000);

    // start while busy is dropped
    spur_k = 10;
    model_push(); run_table("t2_spur", 3000);
    spur_k = 0;

    // 300 ms delay: 3000 cycles in DLY plus FETCH/DECODE overhead
    fill_end();
    rom[0] = e_dly(300);
    model_push(); run_table("t3", 4000);
    check_range("t3_done_cycle", done_k, 3000, 3010);

    // Engine never answers the first byte -> timeout
    fill_end();
    rom[0] = e_wr(8'h00, 8'h0B, 8'h24);
    eng_hang = 1;
    model_push();
    exp_q.delete(); exp_q.push_back({1'b0, 8'h01}); exp_code = 1; exp_nbytes = 1;
    run_table("t4", 1000);
    check_range("t4_timeout_cycles", end_k - first_req_k, 95, 105);
    eng_hang = 0;
    model_push(); run_table("t4_restart", 3000);

    // Table with no END runs off the last slot
    fill_end();
    for (int j = 0; j < DEPTH; j++) rom[j] = e_wr(8'h05, 8'(j), 8'($urandom));
    model_push(); run_table("t5_overrun", 5000);

`ifdef SI5341_VERIFY_EN
    fill_end();
    rom[0] = e_wr(8'h00, 8'h0B, 8'h24);
    vr_corrupt = 1;
    model_push(); run_table("t6_vr_bad", 2000);
    vr_corrupt = 0;
    model_push(); run_table("t6_vr_ok", 2000);
`endif

    // Random tables
    lat_min = 1; lat_max = 8;
    for (int it = 0; it < 6; it++) begin
      int n;
      fill_end();
      n = $urandom_range(1, 10);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) < 7)
          rom[j] = e_wr(8'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
        else
          rom[j] = e_dly($urandom_range(0, 2));
      end
      rom[n] = e_end(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11);
      model_push(); run_table("rnd", 5000);
    end

    // Reset in the middle of a delay, then restart from entry 0
    fill_end();
    rom[0] = e_dly(0); rom[1] = e_dly(50);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(negedge clk);
    check("t7_in_delay_addr", rom_addr, 1);
    check("t7_in_delay_busy", busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_rst("t7_midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_end();
    rom[0] = e_wr(8'h00, 8'h0B, 8'h24); rom[1] = e_wr(8'h00, 8'h0C, 8'h01);
    model_push(); run_table("t7_restart", 3000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
